// File: rtl/change_dispenser.sv
// Sequential change dispenser: compares cost and paid, then pays the change
// out greedily one coin per ready/valid handshake from on-chip inventory.
module change_dispenser #(
  parameter  int VAL_W     = 6,
  parameter  int CNT_W     = 3,
  parameter  int COIN_A    = 5,
  parameter  int COIN_B    = 3,
  parameter  int COIN_C    = 1,
  parameter  int MAX_COINS = 4,
  localparam int NC_W      = $clog2(MAX_COINS + 1)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [VAL_W-1:0] cost,
  input  logic [VAL_W-1:0] paid,
  input  logic             restock,
  input  logic [CNT_W-1:0] restock_a,
  input  logic [CNT_W-1:0] restock_b,
  input  logic [CNT_W-1:0] restock_c,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic             exact_amount,
  output logic             cough_up_more,
  output logic             not_enough_change,
  output logic [VAL_W-1:0] remaining,
  output logic [NC_W-1:0]  coins_given,
  output logic [CNT_W-1:0] inv_a,
  output logic [CNT_W-1:0] inv_b,
  output logic [CNT_W-1:0] inv_c
);

  localparam logic [VAL_W-1:0] LP_VAL_A = VAL_W'(COIN_A);
  localparam logic [VAL_W-1:0] LP_VAL_B = VAL_W'(COIN_B);
  localparam logic [VAL_W-1:0] LP_VAL_C = VAL_W'(COIN_C);
  localparam logic [NC_W-1:0]  LP_MAX   = NC_W'(MAX_COINS);

  localparam logic [1:0] LP_SEL_NONE = 2'b00;
  localparam logic [1:0] LP_SEL_A    = 2'b01;
  localparam logic [1:0] LP_SEL_B    = 2'b10;
  localparam logic [1:0] LP_SEL_C    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } st_t;

  st_t              r_state;
  st_t              w_next_state;
  logic [VAL_W-1:0] r_cost;
  logic [VAL_W-1:0] r_paid;
  logic [VAL_W-1:0] r_remaining;
  logic [NC_W-1:0]  r_coins_given;
  logic [CNT_W-1:0] r_inv_a;
  logic [CNT_W-1:0] r_inv_b;
  logic [CNT_W-1:0] r_inv_c;
  logic             r_exact;
  logic             r_cough;
  logic             r_short;
  logic [1:0]       w_sel;
  logic [VAL_W-1:0] w_coin_val;
  logic             w_fire;

  function automatic logic [VAL_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      LP_SEL_A: coin_value = LP_VAL_A;
      LP_SEL_B: coin_value = LP_VAL_B;
      LP_SEL_C: coin_value = LP_VAL_C;
      default:  coin_value = '0;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Greedy coin selection from registered state only; the per-transaction cap gates every denomination
  always_comb begin
    w_sel = LP_SEL_NONE;
    if (r_state == ST_DISPENSE && r_coins_given < LP_MAX) begin
      if (r_remaining >= LP_VAL_A && r_inv_a != '0) begin
        w_sel = LP_SEL_A;
      end else if (r_remaining >= LP_VAL_B && r_inv_b != '0) begin
        w_sel = LP_SEL_B;
      end else if (r_remaining >= LP_VAL_C && r_inv_c != '0) begin
        w_sel = LP_SEL_C;
      end else begin
        w_sel = LP_SEL_NONE;
      end
    end else begin
      w_sel = LP_SEL_NONE;
    end
  end

  assign w_coin_val = coin_value(w_sel);
  assign w_fire     = (w_sel != LP_SEL_NONE) && coin_ready;

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_EVAL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (r_paid > r_cost) begin
          w_next_state = ST_DISPENSE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (w_sel == LP_SEL_NONE) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_DISPENSE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    coin_valid = 1'b0;
    coin_type  = LP_SEL_NONE;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_EVAL: begin
        busy = 1'b1;
      end
      ST_DISPENSE: begin
        busy       = 1'b1;
        coin_valid = (w_sel != LP_SEL_NONE);
        coin_type  = w_sel;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Transaction datapath: purchase capture, evaluation, per-coin bookkeeping and inventory
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_cost        <= '0;
      r_paid        <= '0;
      r_remaining   <= '0;
      r_coins_given <= '0;
      r_inv_a       <= '0;
      r_inv_b       <= '0;
      r_inv_c       <= '0;
      r_exact       <= 1'b0;
      r_cough       <= 1'b0;
      r_short       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (restock) begin
            r_inv_a <= restock_a;
            r_inv_b <= restock_b;
            r_inv_c <= restock_c;
          end
          if (start) begin
            r_cost        <= cost;
            r_paid        <= paid;
            r_coins_given <= '0;
            r_exact       <= 1'b0;
            r_cough       <= 1'b0;
            r_short       <= 1'b0;
          end
        end
        ST_EVAL: begin
          if (r_paid < r_cost) begin
            r_cough     <= 1'b1;
            r_remaining <= '0;
          end else if (r_paid == r_cost) begin
            r_exact     <= (r_paid != '0);
            r_remaining <= '0;
          end else begin
            r_remaining <= r_paid - r_cost;
          end
        end
        ST_DISPENSE: begin
          if (w_fire) begin
            r_remaining   <= r_remaining - w_coin_val;
            r_coins_given <= r_coins_given + NC_W'(1);
            case (w_sel)
              LP_SEL_A: r_inv_a <= r_inv_a - CNT_W'(1);
              LP_SEL_B: r_inv_b <= r_inv_b - CNT_W'(1);
              LP_SEL_C: r_inv_c <= r_inv_c - CNT_W'(1);
              default:  r_inv_a <= r_inv_a;
            endcase
          end else if (w_sel == LP_SEL_NONE) begin
            // Leaving with change still owed; inventory already paid out stays spent
            r_short <= (r_remaining != '0);
          end
        end
        ST_DONE: begin
          r_remaining <= r_remaining;
        end
        default: begin
          r_remaining <= r_remaining;
        end
      endcase
    end
  end

  assign exact_amount      = r_exact;
  assign cough_up_more     = r_cough;
  assign not_enough_change = r_short;
  assign remaining         = r_remaining;
  assign coins_given       = r_coins_given;
  assign inv_a             = r_inv_a;
  assign inv_b             = r_inv_b;
  assign inv_c             = r_inv_c;

endmodule
